// File: rtl/neo_pkg.sv
// Shared types and width helpers for the NEO spike detector.
package neo_pkg;

  typedef enum logic [1:0] {
    WARMUP     = 2'd0,
    ARMED      = 2'd1,
    REFRACTORY = 2'd2
  } fsm_t;

  // NEO output width for an N-bit raw sample.
  function automatic int neo_w(input int n);
    return 2 * n + 1;
  endfunction

  // Width that holds avg*K without truncation.
  function automatic int thr_w(input int nw, input int k);
    return nw + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/neo_ema.sv
// Clamped exponential moving average of the NEO stream; the first sample seeds avg.
module neo_ema
  import neo_pkg::*;
#(
  parameter int NW          = 33,
  parameter int ALPHA_SHIFT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [NW-1:0] x_raw,
  output logic [NW-1:0] x_clamp,
  output logic [NW-1:0] avg
);

  logic [NW-1:0]        avg_q, avg_d;
  logic                 loaded_q, loaded_d;
  logic signed [NW:0]   diff;
  logic signed [NW:0]   step;

  assign x_clamp = x_raw[NW-1] ? '0 : x_raw;
  assign avg     = avg_q;

  always_comb begin
    diff     = $signed({1'b0, x_clamp}) - $signed({1'b0, avg_q});
    step     = diff >>> ALPHA_SHIFT;
    avg_d    = avg_q;
    loaded_d = loaded_q;
    if (en) begin
      loaded_d = 1'b1;
      // Result always lies between avg and x, so the low NW bits are exact.
      avg_d    = loaded_q ? (avg_q + NW'(step)) : x_clamp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      avg_q    <= avg_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: rtl/neo_spike_detector.sv
// Adaptive-threshold spike detector on the NEO energy stream, with refractory window.
module neo_spike_detector
  import neo_pkg::*;
#(
  parameter int N           = 16,
  parameter int ALPHA_SHIFT = 4,
  parameter int K           = 8,
  parameter int REFR        = 4,
  parameter int CW          = 16,
  localparam int NW         = neo_w(N),
  localparam int TW         = thr_w(NW, K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          neo_valid,
  input  logic [NW-1:0] neo_data,
  output logic          neo_ready,
  output logic          spike,
  output logic [31:0]   spike_index,
  output logic [NW-1:0] spike_amp,
  output logic [TW-1:0] threshold,
  output logic [CW-1:0] spike_count,
  output logic [1:0]    state_o
);

  localparam int            RW        = $clog2(REFR + 1);
  localparam logic [31:0]   WARM_LAST = 32'((1 << ALPHA_SHIFT) - 1);
  localparam logic [TW-1:0] K_T       = TW'(K);

  fsm_t          state_q, state_d;
  logic          ready_q;
  logic [31:0]   sample_cnt_q, sample_cnt_d;
  logic [RW-1:0] refr_q, refr_d;
  logic [CW-1:0] count_q, count_d;
  logic          spike_q, spike_d;
  logic [31:0]   idx_q, idx_d;
  logic [NW-1:0] amp_q, amp_d;

  logic          accept;
  logic          ema_en;
  logic          hit;
  logic [NW-1:0] x_clamp;
  logic [NW-1:0] avg;
  logic [TW-1:0] x_ext;

  neo_ema #(.NW(NW), .ALPHA_SHIFT(ALPHA_SHIFT)) u_ema (
    .clk     (clk),
    .reset   (reset),
    .en      (ema_en),
    .x_raw   (neo_data),
    .x_clamp (x_clamp),
    .avg     (avg)
  );

  assign accept    = neo_valid & ready_q;
  assign threshold = {{(TW-NW){1'b0}}, avg} * K_T;
  assign x_ext     = {{(TW-NW){1'b0}}, x_clamp};
  // Compared against the pre-update avg: the EMA only moves on this same edge.
  assign hit       = x_ext > threshold;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    refr_d       = refr_q;
    count_d      = count_q;
    spike_d      = 1'b0;
    idx_d        = idx_q;
    amp_d        = amp_q;
    ema_en       = 1'b0;
    if (accept) begin
      sample_cnt_d = sample_cnt_q + 32'd1;
      case (state_q)
        WARMUP: begin
          ema_en = 1'b1;
          if (sample_cnt_q == WARM_LAST) state_d = ARMED;
        end
        ARMED: begin
          if (hit) begin
            spike_d = 1'b1;
            idx_d   = sample_cnt_q;
            amp_d   = x_clamp;
            if (count_q != '1) count_d = count_q + 1'b1;
            refr_d  = RW'(REFR);
            state_d = REFRACTORY;
          end else begin
            ema_en = 1'b1;
          end
        end
        REFRACTORY: begin
          refr_d = refr_q - 1'b1;
          if (refr_q == RW'(1)) state_d = ARMED;
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WARMUP;
      ready_q      <= 1'b0;
      sample_cnt_q <= '0;
      refr_q       <= '0;
      count_q      <= '0;
      spike_q      <= 1'b0;
      idx_q        <= '0;
      amp_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= 1'b1;
      sample_cnt_q <= sample_cnt_d;
      refr_q       <= refr_d;
      count_q      <= count_d;
      spike_q      <= spike_d;
      idx_q        <= idx_d;
      amp_q        <= amp_d;
    end
  end

  assign neo_ready   = ready_q;
  assign spike       = spike_q;
  assign spike_index = idx_q;
  assign spike_amp   = amp_q;
  assign spike_count = count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_neo_spike_detector.sv
// Directed bench: vector table for warm-up/detect/refractory, hand sequences for corners.
module tb_neo_spike_detector;

  localparam int NW = 33;
  localparam int TW = 37;
  localparam int CW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 neo_valid = 1'b0;
  logic signed [NW-1:0] neo_data = '0;

  logic          ready1, spike1, ready2, spike2;
  logic [31:0]   idx1, idx2;
  logic [NW-1:0] amp1, amp2;
  logic [TW-1:0] thr1, thr2;
  logic [CW-1:0] cnt1;
  logic [1:0]    cnt2;
  logic [1:0]    st1, st2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neo_spike_detector dut (
    .clk(clk), .reset(rst_n), .neo_valid(neo_valid), .neo_data(neo_data),
    .neo_ready(ready1), .spike(spike1), .spike_index(idx1), .spike_amp(amp1),
    .threshold(thr1), .spike_count(cnt1), .state_o(st1)
  );

  neo_spike_detector #(.CW(2)) dut_sat (
    .clk(clk), .reset(rst_n), .neo_valid(neo_valid), .neo_data(neo_data),
    .neo_ready(ready2), .spike(spike2), .spike_index(idx2), .spike_amp(amp2),
    .threshold(thr2), .spike_count(cnt2), .state_o(st2)
  );

  typedef struct {
    logic signed [NW-1:0] data;
    logic                 sp;
    logic [31:0]          idx;
    logic [NW-1:0]        amp;
    logic [TW-1:0]        thr;
    logic [CW-1:0]        cnt;
    logic [1:0]           st;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input longint d, input bit sp, input int idx,
                              input longint amp, input longint thr, input int cnt,
                              input int st);
    vec_t v;
    v.data = NW'(d);
    v.sp   = sp;
    v.idx  = 32'(idx);
    v.amp  = NW'(amp);
    v.thr  = TW'(thr);
    v.cnt  = CW'(cnt);
    v.st   = 2'(st);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one sample; returns at the next falling edge, after the accepting edge.
  task automatic send(input logic signed [NW-1:0] v);
    neo_valid = 1'b1;
    neo_data  = v;
    @(negedge clk);
  endtask

  task automatic idle();
    neo_valid = 1'b0;
    neo_data  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic warm();
    for (int i = 0; i < 16; i++) send(100);
  endtask

  initial begin
    // Warm-up at 100, spike at 16, refractory 17..20, spike again at 21.
    for (int i = 0; i < 16; i++) tbl[i] = mk(100, 0, 0, 0, 800, 0, (i == 15) ? 1 : 0);
    tbl[16] = mk(801, 1, 16, 801, 800, 1, 2);
    for (int i = 17; i < 21; i++) tbl[i] = mk(5000, 0, 16, 801, 800, 1, (i == 20) ? 1 : 2);
    tbl[21] = mk(5000, 1, 21, 5000, 800, 2, 2);

    // Reset / idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 64'(ready1), 0);
    chk("state_in_reset", 64'(st1), 0);
    chk("thr_in_reset", 64'(thr1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(ready1), 1);
    repeat (2) @(negedge clk);
    chk("idle_spike", 64'(spike1), 0);
    chk("idle_count", 64'(cnt1), 0);
    chk("idle_index", 64'(idx1), 0);
    chk("idle_amp", 64'(amp1), 0);
    chk("idle_state", 64'(st1), 0);

    // Table run, back-to-back samples
    for (int i = 0; i < 22; i++) begin
      send(tbl[i].data);
      chk($sformatf("v%0d_spike", i), 64'(spike1), 64'(tbl[i].sp));
      chk($sformatf("v%0d_index", i), 64'(idx1), 64'(tbl[i].idx));
      chk($sformatf("v%0d_amp", i), 64'(amp1), 64'(tbl[i].amp));
      chk($sformatf("v%0d_thr", i), 64'(thr1), 64'(tbl[i].thr));
      chk($sformatf("v%0d_count", i), 64'(cnt1), 64'(tbl[i].cnt));
      chk($sformatf("v%0d_state", i), 64'(st1), 64'(tbl[i].st));
    end
    idle();
    @(negedge clk);
    chk("spike_one_cycle", 64'(spike1), 0);
    chk("index_hold", 64'(idx1), 21);

    // Big sample during warm-up: moves avg, never detected
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send((i == 5) ? 33'sd5000 : 33'sd100);
      chk($sformatf("wu%0d_nospike", i), 64'(spike1), 0);
      if (i == 5) chk("wu_big_thr", 64'(thr1), 406 * 8);
    end
    chk("wu_armed", 64'(st1), 1);

    // Exactly at threshold: no detection, avg moves to 143
    do_reset();
    warm();
    send(800);
    chk("eq_nospike", 64'(spike1), 0);
    chk("eq_thr", 64'(thr1), 143 * 8);
    chk("eq_state", 64'(st1), 1);

    // Negative NEO is clamped to 0
    do_reset();
    warm();
    send(-33'sd300);
    chk("neg_nospike", 64'(spike1), 0);
    chk("neg_thr", 64'(thr1), 93 * 8);

    // Asynchronous reset in refractory
    do_reset();
    warm();
    send(801);
    send(5000);
    idle();
    chk("pre_rst_state", 64'(st1), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 64'(st1), 0);
    chk("mid_rst_count", 64'(cnt1), 0);
    chk("mid_rst_index", 64'(idx1), 0);
    chk("mid_rst_ready", 64'(ready1), 0);
    chk("mid_rst_thr", 64'(thr1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Saturation of a 2-bit spike counter
    warm();
    for (int s = 0; s < 5; s++) begin
      send(801);
      chk($sformatf("sat%0d_spike", s), 64'(spike2), 1);
      chk($sformatf("sat%0d_count", s), 64'(cnt2), (s + 1 > 3) ? 3 : s + 1);
      chk($sformatf("sat%0d_count16", s), 64'(cnt1), 64'(s + 1));
      for (int f = 0; f < 4; f++) send(0);
      chk($sformatf("sat%0d_quiet", s), 64'(spike2), 0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neo_spike_detector.md
Name: neo_spike_detector

Overview:
- Downstream consumer of the NEO calculator output stream.
- Receives one NEO energy sample per handshake and tracks an adaptive baseline with an exponential moving average (EMA).
- Flags a spike when a sample exceeds K times the baseline, then enforces a refractory window.
- Reports spike events, sample index and running spike count to the system level.

Parameters:
- N, 16: raw sample width; NEO input width is NW = 2*N+1 (signed).
- ALPHA_SHIFT, 4: EMA weight 2^-ALPHA_SHIFT; the warm-up length is 2^ALPHA_SHIFT samples.
- K, 8: threshold multiplier (unsigned integer, ≥1).
- REFR, 4: refractory length, counted in accepted samples (≥1).
- CW, 16: spike counter width.

Ports:
- Clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- neo_valid, input, 1: NEO sample valid.
- neo_data, input, NW: signed NEO value.
- neo_ready, output, 1: block can accept a sample.
- spike, output, 1: one-cycle pulse on detection.
- spike_index, output, 32: index of the detected sample (0-based accepted-sample count).
- spike_amp, output, NW: clamped amplitude of the detected sample.
- threshold, output, NW+$clog2(K)+1: current K*avg.
- spike_count, output, CW: total spikes detected, saturating.
- state_o, output, 2: current FSM state (debug).

Behaviour:
- Reset (reset=0, asynchronous) clears all registers:
  - avg=0, sample counter=0, refractory counter=0, spike_count=0, spike=0, spike_index=0, spike_amp=0.
  - State is WARMUP.
  - neo_ready=0 while reset is asserted; neo_ready=1 from the first clock edge after deassertion, then stays 1 (one sample per cycle).
- A sample is accepted on a rising edge with neo_valid=1 and neo_ready=1. Nothing changes on cycles with no accepted sample.
- Clamp: x = max(neo_data, 0). Negative NEO values are treated as 0 everywhere.
- EMA update: avg_next = avg + ((x - avg) >>> ALPHA_SHIFT). The subtraction uses NW+1 signed bits, so avg stays in [0, 2^(NW-1)-1].
  - Exception: the very first accepted sample after reset loads avg = x directly.
- Threshold is combinational from the registered avg: threshold = avg*K at full width, no truncation.
- Comparison is strictly greater (x > threshold), made against the avg value held before this sample's update.
- FSM, advanced on accepted samples only:
  - WARMUP: update avg; no detection. After 2^ALPHA_SHIFT accepted samples (counted from reset, including the first), go to ARMED.
  - ARMED: if x > threshold, this is a detection:
    - spike=1 on the next cycle; spike_index = current sample counter; spike_amp = x.
    - spike_count increments, saturating at 2^CW-1.
    - avg is NOT updated.
    - Go to REFRACTORY with refractory counter = REFR.
  - ARMED, otherwise: update avg; stay in ARMED.
  - REFRACTORY: avg is not updated; no detection. Counter decrements on each accepted sample; when it reaches 0, go to ARMED.
  - The first sample eligible for detection is the (REFR+1)-th sample after the spike sample.
- Latency: spike, spike_index and spike_amp are registered, valid the cycle after the accepting edge. spike is high for exactly one cycle; spike_index and spike_amp hold until the next detection.
- Sample counter: 32 bits, wraps modulo 2^32. Wrap does not affect FSM or avg.
- Back-to-back valid samples in consecutive cycles are fully supported; no bubbles are required.
- Reset asserted mid-refractory or mid-warm-up aborts immediately to the reset state.

Decomposition:
- Package neo_pkg holds:
  - state enum fsm_t {WARMUP, ARMED, REFRACTORY}.
  - localparam function for NW.
  - Threshold width helper.
- One natural sub-module, neo_ema: clamp, first-sample load, and the shift-subtract-add update with an enable.
- The FSM, comparator and counters stay in neo_spike_detector.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release → all outputs 0, state_o=WARMUP, neo_ready=1 after the first edge, no spike with neo_valid=0.
- Warm-up: 16 samples of 100 → avg=100, threshold=800, no spike even if a sample during warm-up is 5000 (that sample shifts avg; rerun without it for the later tests); state_o=ARMED after the 16th sample.
- Strict threshold: after warm-up at 100, send 800 → no spike, avg stays 100 + (700>>>4) = 143. Fresh run: send 801 → spike pulse, spike_index=16, spike_amp=801, spike_count=1, avg stays 100.
- Refractory: after a spike at index 16, send samples 17–20 = 5000 → no spike, avg unchanged at 100. Sample 21 = 5000 → spike, spike_index=21, spike_count=2.
- Negative clamp: after warm-up at 100, send -300 → treated as 0, avg = 100 + ((0-100)>>>4) = 93, no spike.
- Reset mid-refractory plus saturation:
  - Assert reset during REFRACTORY → immediate WARMUP, counters 0.
  - Separate run with CW=2: 5 qualifying spikes → spike_count saturates at 3 while spike still pulses each time.
